xc_rf_banked: RTL
=================

// Module: xc_rf_banked
//
// PURPOSE
//  Parametrised 1-write/NRP-read register file split into even/odd banks,
//  with a double-width writeback to adjacent register pairs. It is the next
//  generation of the XCrypto GPR file and sits between decode (reads) and
//  writeback. It adds two features: optional write-to-read bypass, and a
//  sequenced secure wipe that zeroises all registers, with a handshake.
//
// PARAMETERS
//  XLEN    32  register width in bits
//  NREGS   32  number of registers; power of two, >= 4; register 0 is hardwired zero
//  NRP     2   number of read ports, 1..4
//  BYPASS  1   1: a read of a register written this cycle returns the write data
//
// PORTS
//  clock          in   1             rising-edge clock
//  resetn         in   1             asynchronous, active-low reset
//  rs_addr        in   NRP*AW        packed read addresses, port p at [p*AW +: AW], AW=log2(NREGS)
//  rs_rdata       out  NRP*XLEN      packed read data, combinational
//  rd_wen         in   1             write enable
//  rd_wide        in   1             write the pair {rd_addr|1, rd_addr} with {rd_wdata_hi, rd_wdata}
//  rd_addr        in   AW            write address
//  rd_wdata       in   XLEN          write data (low half when wide)
//  rd_wdata_hi    in   XLEN          high-half write data, used only when wide
//  rd_ready       out  1             1 = writes accepted; equals !wipe_busy
//  wide_err       out  1             registered 1-cycle pulse: a wide write used an odd rd_addr
//  wipe_req       in   1             start a wipe; sampled only in IDLE
//  wipe_busy      out  1             a wipe is in progress
//  wipe_done      out  1             registered 1-cycle pulse when the wipe completes
//
// BEHAVIOUR
//  - Reset (async, resetn=0): all registers = 0; FSM = IDLE; wipe_busy=0,
//    wipe_done=0, wide_err=0, rd_ready=1.
//  - Reads: rs_rdata[p] = reg[rs_addr[p]]; address 0 always reads 0.
//    While wipe_busy=1, all read ports return 0.
//  - Narrow write (rd_wen=1, rd_wide=0, rd_ready=1): reg[rd_addr] <= rd_wdata
//    at the clock edge. A write to register 0 is discarded.
//  - Wide write with rd_addr even: reg[rd_addr] <= rd_wdata and
//    reg[rd_addr+1] <= rd_wdata_hi in the same edge. For pair 0, only reg1 is written.
//  - Wide write with rd_addr odd: nothing is written; wide_err=1 on the next cycle.
//  - Writes presented while rd_ready=0 are dropped silently; no error is raised.
//  - Bypass (BYPASS=1, not busy): if a read address matches a register being
//    written this cycle (either half of a wide write, never reg 0), that port
//    returns the new data combinationally. With BYPASS=0, the port returns the old value.
//  - Wipe FSM, states IDLE -> WIPE -> DONE -> IDLE:
//      IDLE: wipe_req=1 -> WIPE; pair counter cnt <= 0. A write in the same
//            cycle as wipe_req is still accepted.
//      WIPE: per cycle, clear even[cnt] and odd[cnt]; cnt++. After
//            cnt = NREGS/2-1 -> DONE. wipe_busy=1 throughout.
//      DONE: wipe_done=1, wipe_busy=0 for one cycle -> IDLE.
//    Latency: request at edge t gives busy for NREGS/2 cycles, then done.
//    wipe_req is ignored in WIPE and DONE.
//  - Reset asserted mid-wipe aborts the wipe: all registers are cleared
//    asynchronously and the FSM goes to IDLE. No wipe_done is produced.
//  - cnt is log2(NREGS)-1 bits wide and must not wrap inside WIPE.
//
// STRUCTURE
//  - Shared header xc_rf_defs.vh holds:
//      * FSM state encodings (RF_IDLE=2'd0, RF_WIPE=2'd1, RF_DONE=2'd2);
//      * the AW computation macro.
//  - Sub-module xc_rf_bank holds NREGS/2 x XLEN storage, with:
//      * one write port and one synchronous clear port (clr, clr_idx);
//      * NRP combinational read ports.
//    It is instantiated twice (even and odd). The top level holds address
//    split, pairing, bypass muxes, wide_err and the wipe FSM.
//
// TESTING
//  1. Narrow write reg5=0xDEADBEEF, then read both ports at 5 -> 0xDEADBEEF;
//     write reg0=0x1 -> reg0 still reads 0.
//  2. Wide write rd_addr=6, lo=0x11111111, hi=0x22222222 -> reg6=0x11111111,
//     reg7=0x22222222; wide write rd_addr=0 -> reg0=0, reg1=hi.
//  3. Wide write rd_addr=9 -> no registers change; wide_err=1 for exactly one cycle.
//  4. BYPASS=1: write reg3=0xA5A5A5A5 while reading 3 in the same cycle ->
//     rs_rdata=0xA5A5A5A5 in that cycle; with BYPASS=0 -> old value.
//  5. Fill all regs with non-zero data, pulse wipe_req ->
//     busy for 16 cycles (NREGS=32), reads return 0, writes are dropped;
//     then wipe_done pulses and every register reads 0.
//  6. Assert resetn low at wipe cycle 5 -> all registers are 0, busy=0,
//     no wipe_done; a new wipe_req after reset completes normally.

Source files
------------

// File: rtl/xc_rf_banked_pkg.sv
// Shared definitions for the banked register file: wipe FSM states and the
// address-width helper.
package xc_rf_banked_pkg;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_WIPE = 2'd1,
    RF_DONE = 2'd2
  } rf_state_e;

  // Register-address width for a file of n registers.
  function automatic int unsigned rf_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/xc_rf_banked_bank.sv
// xc_rf_bank: one bank (even or odd registers) of the banked register file.
//   i_clock / i_resetn : clock, async active-low reset (clears every entry)
//   i_we, i_widx, i_wdata : single write port
//   i_clr, i_clr_idx      : synchronous clear of one entry (wins over write)
//   i_raddr / o_rdata     : NRP packed combinational read ports
module xc_rf_bank #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned NRP   = 2,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic              i_clr,
  input  logic [IW-1:0]     i_clr_idx,
  input  logic [NRP*IW-1:0] i_raddr,
  output logic [NRP*XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_mem <= '{default: '0};
    end else begin
      if (i_we)  r_mem[i_widx]    <= i_wdata;
      if (i_clr) r_mem[i_clr_idx] <= '0;
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      o_rdata[p*XLEN +: XLEN] = r_mem[i_raddr[p*IW +: IW]];
    end
  end

endmodule

// File: rtl/xc_rf_banked.sv
// xc_rf_banked: 1-write / NRP-read register file split into even/odd banks,
// with double-width pair writeback, optional write-to-read bypass and a
// sequenced secure wipe.
//   clock, resetn        : clock, async active-low reset
//   rs_addr / rs_rdata   : packed read ports (combinational, reg 0 reads 0)
//   rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi : writeback port
//   rd_ready             : writes accepted (not wiping)
//   wide_err             : 1-cycle pulse after a wide write with odd rd_addr
//   wipe_req / wipe_busy / wipe_done : wipe handshake
module xc_rf_banked
  import xc_rf_banked_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NRP    = 2,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = rf_aw(NREGS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_rdata,
  input  logic                rd_wen,
  input  logic                rd_wide,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_wdata,
  input  logic [XLEN-1:0]     rd_wdata_hi,
  output logic                rd_ready,
  output logic                wide_err,
  input  logic                wipe_req,
  output logic                wipe_busy,
  output logic                wipe_done
);

  localparam int unsigned IW = AW - 1;
  localparam int unsigned NB = NREGS / 2;

  rf_state_e         r_state, w_state_nxt;
  logic [IW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_wide_err;
  logic              w_busy, w_acc, w_clr;
  logic              w_we_e, w_we_o;
  logic [XLEN-1:0]   w_wd_e, w_wd_o;
  logic [IW-1:0]     w_idx;
  logic [NRP*IW-1:0] w_raddr;
  logic [NRP*XLEN-1:0] w_rd_e, w_rd_o;
  logic [AW-1:0]     w_a;
  logic              w_hit;

  assign w_busy = (r_state == RF_WIPE);
  assign w_acc  = rd_wen & ~w_busy;
  assign w_idx  = rd_addr[AW-1:1];

  // Even bank is skipped for address 0 (hardwired zero); a wide write to an
  // odd address touches neither bank.
  always_comb begin
    w_we_e = w_acc & ~rd_addr[0] & (rd_addr != '0);
    w_we_o = w_acc & (rd_wide ? ~rd_addr[0] : rd_addr[0]);
    w_wd_e = rd_wdata;
    w_wd_o = rd_wide ? rd_wdata_hi : rd_wdata;
  end

  always_comb begin
    w_raddr = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      w_raddr[p*IW +: IW] = rs_addr[p*AW+1 +: IW];
    end
  end

  xc_rf_bank #(.XLEN(XLEN), .DEPTH(NB), .NRP(NRP)) u_even (
    .i_clock  (clock),
    .i_resetn (resetn),
    .i_we     (w_we_e),
    .i_widx   (w_idx),
    .i_wdata  (w_wd_e),
    .i_clr    (w_clr),
    .i_clr_idx(r_cnt),
    .i_raddr  (w_raddr),
    .o_rdata  (w_rd_e)
  );

  xc_rf_bank #(.XLEN(XLEN), .DEPTH(NB), .NRP(NRP)) u_odd (
    .i_clock  (clock),
    .i_resetn (resetn),
    .i_we     (w_we_o),
    .i_widx   (w_idx),
    .i_wdata  (w_wd_o),
    .i_clr    (w_clr),
    .i_clr_idx(r_cnt),
    .i_raddr  (w_raddr),
    .o_rdata  (w_rd_o)
  );

  always_comb begin
    rs_rdata = '0;
    w_a      = '0;
    w_hit    = 1'b0;
    for (int unsigned p = 0; p < NRP; p++) begin
      w_a   = rs_addr[p*AW +: AW];
      w_hit = (BYPASS != 0) && (w_a[AW-1:1] == w_idx) &&
              (w_a[0] ? w_we_o : w_we_e);
      if (w_busy || (w_a == '0))
        rs_rdata[p*XLEN +: XLEN] = '0;
      else if (w_hit)
        rs_rdata[p*XLEN +: XLEN] = w_a[0] ? w_wd_o : w_wd_e;
      else
        rs_rdata[p*XLEN +: XLEN] = w_a[0] ? w_rd_o[p*XLEN +: XLEN]
                                          : w_rd_e[p*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= RF_IDLE;
      r_cnt      <= '0;
      r_wide_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wide_err <= w_acc & rd_wide & rd_addr[0];
    end
  end

  // The counter holds on the last pair instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    case (r_state)
      RF_IDLE: if (wipe_req) begin
        w_state_nxt = RF_WIPE;
        w_cnt_nxt   = '0;
      end
      RF_WIPE: begin
        w_clr = 1'b1;
        if (r_cnt == IW'(NB - 1)) w_state_nxt = RF_DONE;
        else                      w_cnt_nxt   = r_cnt + 1'b1;
      end
      RF_DONE: w_state_nxt = RF_IDLE;
      default: w_state_nxt = RF_IDLE;
    endcase
  end

  assign wipe_busy = w_busy;
  assign wipe_done = (r_state == RF_DONE);
  assign rd_ready  = ~w_busy;
  assign wide_err  = r_wide_err;

endmodule
